// File: rtl/q_link_pkg.sv
// q_link_pkg
//   Definitions shared by every block on the q_serialized link: the
//   transmitter state encoding, the defaults that the transmitter, the
//   q_measurement receiver and resonant_sys must agree on, and the
//   end-of-frame gap length derived from the receiver watchdog width.
package q_link_pkg;

  localparam int Q_PER_PULSE_DEFAULT    = 30;
  localparam int PULSE_DURATION_DEFAULT = 3;

  typedef enum logic [2:0] {
    IDLE,
    DIVIDE,
    PULSE_HI,
    PULSE_LO,
    END_GAP,
    DONE
  } q_ser_state_t;

  // Silence the receiver needs to see before its watchdog closes the
  // window: one full watchdog wrap plus a cycle of margin.
  function automatic int end_gap_len(input int wtd_bus_width);
    return (1 << wtd_bus_width) + 1;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/q_quantizer.sv
// q_quantizer
//   Iterative restoring divider: n_pulses = floor(q_value / Q_PER_PULSE),
//   one subtraction per enabled cycle. The remainder is discarded.
//   Ports:
//     clk, rst      clock, asynchronous active-high reset
//     start         load q_value into the remainder and clear the quotient
//     step          perform one subtraction if the remainder allows it
//     q_value       dividend, sampled with start
//     quotient_done remainder has dropped below Q_PER_PULSE
//     n_pulses      running / final quotient
module q_quantizer
  import q_link_pkg::*;
#(
  parameter int BUS_WIDTH   = 10,
  parameter int Q_PER_PULSE = Q_PER_PULSE_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 step,
  input  logic [BUS_WIDTH-1:0] q_value,
  output logic                 quotient_done,
  output logic [BUS_WIDTH-1:0] n_pulses
);

  localparam logic [31:0] Q_STEP = 32'(Q_PER_PULSE);

  logic [BUS_WIDTH-1:0] rem;
  logic                 can_sub;

  // Compare at 32 bits so a quantum wider than the bus never truncates.
  assign can_sub       = 32'(rem) >= Q_STEP;
  assign quotient_done = !can_sub;

  // NOTE: sequential state is updated with non-blocking assignments only,
  // so every register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem      <= '0;
      n_pulses <= '0;
    end else if (start) begin
      rem      <= q_value;
      n_pulses <= '0;
    end else if (step && can_sub) begin
      rem      <= rem - Q_STEP[BUS_WIDTH-1:0];
      n_pulses <= n_pulses + 1'b1;
    end
  end

endmodule

// File: rtl/q_pulse_serializer.sv
// q_pulse_serializer
//   Charge-to-pulse transmitter for the q_serialized link. A loaded charge
//   is quantised to floor(q_value / Q_PER_PULSE) pulses, each PULSE_DURATION
//   cycles high and separated by GAP_DURATION low cycles, followed by a
//   silent gap long enough for the receiver watchdog to close its window.
//   Ports:
//     clk, rst      clock, asynchronous active-high reset
//     enable        block enable; low aborts a frame in progress
//     load          frame request, honoured only in IDLE
//     q_value       charge to transmit, sampled with load
//     busy          frame in progress (registered)
//     done          one-cycle strobe on normal frame completion
//     q_serialized  registered pulse train
//     pulses_sent   pulses emitted in the last or current frame
module q_pulse_serializer
  import q_link_pkg::*;
#(
  parameter int BUS_WIDTH      = 10,
  parameter int WTD_BUS_WIDTH  = 2,
  parameter int Q_PER_PULSE    = Q_PER_PULSE_DEFAULT,
  parameter int PULSE_DURATION = PULSE_DURATION_DEFAULT,
  parameter int GAP_DURATION   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 load,
  input  logic [BUS_WIDTH-1:0] q_value,
  output logic                 busy,
  output logic                 done,
  output logic                 q_serialized,
  output logic [BUS_WIDTH-1:0] pulses_sent
);

  localparam int END_GAP_LEN = end_gap_len(WTD_BUS_WIDTH);
  localparam int DUR_MAX     = max3(PULSE_DURATION, GAP_DURATION, END_GAP_LEN);
  localparam int CNT_W       = (DUR_MAX > 1) ? $clog2(DUR_MAX) : 1;

  localparam logic [CNT_W-1:0] HI_LAST  = CNT_W'(PULSE_DURATION - 1);
  localparam logic [CNT_W-1:0] LO_LAST  = CNT_W'(GAP_DURATION - 1);
  localparam logic [CNT_W-1:0] END_LAST = CNT_W'(END_GAP_LEN - 1);

  q_ser_state_t         state, state_next;
  logic [CNT_W-1:0]     dur, dur_next;
  logic [BUS_WIDTH-1:0] pulses_sent_next;
  logic                 qz_start, qz_step, qz_done;
  logic [BUS_WIDTH-1:0] n_pulses;

  q_quantizer #(
    .BUS_WIDTH   (BUS_WIDTH),
    .Q_PER_PULSE (Q_PER_PULSE)
  ) u_quantizer (
    .clk           (clk),
    .rst           (rst),
    .start         (qz_start),
    .step          (qz_step),
    .q_value       (q_value),
    .quotient_done (qz_done),
    .n_pulses      (n_pulses)
  );

  // NOTE: every signal driven here gets a default before the case so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_next       = state;
    dur_next         = '0;
    pulses_sent_next = pulses_sent;
    qz_start         = 1'b0;
    qz_step          = 1'b0;

    case (state)
      IDLE: begin
        if (enable && load) begin
          qz_start         = 1'b1;
          pulses_sent_next = '0;
          state_next       = DIVIDE;
        end
      end
      DIVIDE: begin
        if (!qz_done) qz_step = 1'b1;
        else          state_next = (n_pulses != '0) ? PULSE_HI : END_GAP;
      end
      PULSE_HI: begin
        if (dur == HI_LAST) begin
          pulses_sent_next = pulses_sent + 1'b1;
          state_next       = (pulses_sent_next == n_pulses) ? END_GAP : PULSE_LO;
        end else begin
          dur_next = dur + 1'b1;
        end
      end
      PULSE_LO: begin
        if (dur == LO_LAST) state_next = PULSE_HI;
        else                dur_next   = dur + 1'b1;
      end
      END_GAP: begin
        if (dur == END_LAST) state_next = DONE;
        else                 dur_next   = dur + 1'b1;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase

    // Dropping enable abandons the frame wherever it is; the partial pulse
    // count is kept for inspection and no done strobe is produced.
    if (state != IDLE && !enable) begin
      state_next       = IDLE;
      dur_next         = '0;
      pulses_sent_next = pulses_sent;
      qz_step          = 1'b0;
    end
  end

  // Outputs are registered from the next state so they line up with the
  // state they describe, without any combinational path to the ports.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      dur          <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      q_serialized <= 1'b0;
      pulses_sent  <= '0;
    end else begin
      state        <= state_next;
      dur          <= dur_next;
      busy         <= (state_next != IDLE);
      done         <= (state_next == DONE);
      q_serialized <= (state_next == PULSE_HI);
      pulses_sent  <= pulses_sent_next;
    end
  end

endmodule
